// File: rtl/fifo_frame_pkg.sv
// Shared types and constants for the FIFO frame reader and its bench.
package fifo_frame_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StPay,
        StCsum
    } state_e;

    localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

    // Bytes on the stream per frame: header, payload, checksum.
    function automatic int unsigned frame_bytes(input int unsigned frame_len);
        return frame_len + 2;
    endfunction

endpackage

// File: rtl/fifo_frame_reader_if.sv
// FWFT FIFO read side plus valid/ready byte stream seen by the frame reader.
interface fifo_frame_reader_if #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned CNT_W  = 8
);

    logic [DATA_W-1:0] fifo_dout;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_rd_count;
    logic              fifo_rd_en;

    logic [DATA_W-1:0] m_data;
    logic              m_valid;
    logic              m_last;
    logic              m_ready;

    // The reader drains the FIFO and drives the stream.
    modport master (
        input  fifo_dout,
        input  fifo_empty,
        input  fifo_rd_count,
        output fifo_rd_en,
        output m_data,
        output m_valid,
        output m_last,
        input  m_ready
    );

    // FIFO and stream sink as seen from the other side.
    modport slave (
        output fifo_dout,
        output fifo_empty,
        output fifo_rd_count,
        input  fifo_rd_en,
        input  m_data,
        input  m_valid,
        input  m_last,
        output m_ready
    );

endinterface

// File: rtl/fifo_frame_reader.sv
// Drains fixed-length payloads from an FWFT FIFO and emits header/payload/XOR-checksum
// frames on a registered valid/ready byte stream.
module fifo_frame_reader
    import fifo_frame_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       FRAME_LEN = 16,
    parameter logic [DATA_W-1:0] HEADER    = DATA_W'(HEADER_DEFAULT),
    parameter int unsigned       CNT_W     = 8
) (
    input  logic                sys_clk,
    input  logic                sys_rst,
    input  logic                start_en_i,
    fifo_frame_reader_if.master bus_io,
    output logic                busy_o,
    output logic [15:0]         frame_cnt_o
);

    localparam int unsigned IDX_W = $clog2(FRAME_LEN) + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    if (FRAME_LEN < 1 || FRAME_LEN > (32'd1 << (CNT_W - 1))) begin : g_bad_frame_len
        $error("fifo_frame_reader: FRAME_LEN must be in 1..2**(CNT_W-1)");
    end

    state_e            state_q, state_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic              m_valid_q, m_valid_d;
    logic              m_last_q, m_last_d;
    logic [DATA_W-1:0] csum_q, csum_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              busy_q, busy_d;
    logic [15:0]       frame_cnt_q, frame_cnt_d;

    logic load;
    logic start_ok;
    logic pop;

    // The output register may only change when it is empty or being consumed.
    assign load     = !m_valid_q || bus_io.m_ready;
    assign start_ok = start_en_i && (bus_io.fifo_rd_count >= CNT_W'(FRAME_LEN));

    always_comb begin
        state_d     = state_q;
        m_data_d    = m_data_q;
        m_valid_d   = m_valid_q;
        m_last_d    = m_last_q;
        csum_d      = csum_q;
        idx_d       = idx_q;
        busy_d      = busy_q;
        frame_cnt_d = frame_cnt_q;
        pop         = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (load) begin
                    if (start_ok) begin
                        m_data_d  = HEADER;
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b0;
                        csum_d    = '0;
                        idx_d     = '0;
                        busy_d    = 1'b1;
                        state_d   = StPay;
                    end else begin
                        m_valid_d = 1'b0;
                        m_last_d  = 1'b0;
                        busy_d    = 1'b0;
                    end
                end
            end
            StPay: begin
                if (load) begin
                    if (!bus_io.fifo_empty) begin
                        pop       = 1'b1;
                        m_data_d  = bus_io.fifo_dout;
                        m_valid_d = 1'b1;
                        m_last_d  = 1'b0;
                        csum_d    = csum_q ^ bus_io.fifo_dout;
                        idx_d     = idx_q + IDX_W'(1);
                        if (idx_q == LAST_IDX) begin
                            state_d = StCsum;
                        end
                    end else begin
                        // Underflow only if the start gate was bypassed; wait for data.
                        m_valid_d = 1'b0;
                    end
                end
            end
            StCsum: begin
                if (load) begin
                    m_data_d    = csum_q;
                    m_valid_d   = 1'b1;
                    m_last_d    = 1'b1;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                    state_d     = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sys_clk or negedge sys_rst) begin
        if (!sys_rst) begin
            state_q     <= StIdle;
            m_data_q    <= '0;
            m_valid_q   <= 1'b0;
            m_last_q    <= 1'b0;
            csum_q      <= '0;
            idx_q       <= '0;
            busy_q      <= 1'b0;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            m_data_q    <= m_data_d;
            m_valid_q   <= m_valid_d;
            m_last_q    <= m_last_d;
            csum_q      <= csum_d;
            idx_q       <= idx_d;
            busy_q      <= busy_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    assign bus_io.fifo_rd_en = pop;
    assign bus_io.m_data     = m_data_q;
    assign bus_io.m_valid    = m_valid_q;
    assign bus_io.m_last     = m_last_q;
    assign busy_o            = busy_q;
    assign frame_cnt_o       = frame_cnt_q;

endmodule

// File: tb/tb_fifo_frame_reader.sv
// Scoreboard bench: two readers (4- and 16-byte payloads) fed by behavioural FWFT FIFOs.
`timescale 1ns/1ps
module tb_fifo_frame_reader;
    import fifo_frame_pkg::*;

    localparam int unsigned FL   = 4;
    localparam int unsigned FL16 = 16;

    logic sys_clk    = 1'b0;
    logic sys_rst    = 1'b0;
    logic start_en   = 1'b0;
    logic start_en16 = 1'b0;

    always #5 sys_clk = ~sys_clk;

    fifo_frame_reader_if #(.DATA_W(8), .CNT_W(8)) bus4 ();
    fifo_frame_reader_if #(.DATA_W(8), .CNT_W(8)) bus16 ();

    logic        busy4, busy16;
    logic [15:0] fcnt4, fcnt16;

    fifo_frame_reader #(.DATA_W(8), .FRAME_LEN(FL), .HEADER(8'hA5), .CNT_W(8)) u_dut4 (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start_en_i  (start_en),
        .bus_io      (bus4),
        .busy_o      (busy4),
        .frame_cnt_o (fcnt4)
    );

    fifo_frame_reader #(.DATA_W(8), .FRAME_LEN(FL16), .HEADER(8'hA5), .CNT_W(8)) u_dut16 (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .start_en_i  (start_en16),
        .bus_io      (bus16),
        .busy_o      (busy16),
        .frame_cnt_o (fcnt16)
    );

    // Behavioural FWFT FIFOs: contents are src[pop .. wr-1].
    logic [7:0]  src4  [0:255];
    logic [7:0]  src16 [0:255];
    int unsigned wr4 = 0, pop4 = 0, wr16 = 0, pop16 = 0;

    assign bus4.fifo_dout     = src4[pop4[7:0]];
    assign bus4.fifo_rd_count = 8'(wr4 - pop4);
    assign bus4.fifo_empty    = (wr4 == pop4);
    assign bus16.fifo_dout     = src16[pop16[7:0]];
    assign bus16.fifo_rd_count = 8'(wr16 - pop16);
    assign bus16.fifo_empty    = (wr16 == pop16);

    initial forever begin
        @(posedge sys_clk);
        if (bus4.fifo_rd_en) pop4 <= pop4 + 1;
        if (bus16.fifo_rd_en) pop16 <= pop16 + 1;
    end

    int          n_cmp = 0;
    int          n_mis = 0;
    logic [8:0]  sb4[$];
    logic [8:0]  sb16[$];

    task automatic cmp(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte and checks hold stability.
    logic       hold4 = 1'b0, hold16 = 1'b0, hl4 = 1'b0, hl16 = 1'b0;
    logic [7:0] hd4 = '0, hd16 = '0;
    logic [8:0] exp_b;
    initial forever begin
        @(negedge sys_clk);
        if (!sys_rst) begin
            hold4  = 1'b0;
            hold16 = 1'b0;
        end else begin
            if (hold4) begin
                cmp("hold_data4", 32'(bus4.m_data), 32'(hd4));
                cmp("hold_last4", 32'(bus4.m_last), 32'(hl4));
            end
            hold4 = bus4.m_valid && !bus4.m_ready;
            hd4   = bus4.m_data;
            hl4   = bus4.m_last;
            if (bus4.fifo_rd_en) cmp("rd_en_while_empty4", 32'(bus4.fifo_empty), 32'd0);
            if (bus4.m_valid && bus4.m_ready) begin
                if (sb4.size() == 0) begin
                    cmp("unexpected_byte4", 32'({bus4.m_last, bus4.m_data}), 32'h1FF);
                end else begin
                    exp_b = sb4.pop_front();
                    cmp("stream4", 32'({bus4.m_last, bus4.m_data}), 32'(exp_b));
                end
            end
            if (hold16) cmp("hold_data16", 32'(bus16.m_data), 32'(hd16));
            hold16 = bus16.m_valid && !bus16.m_ready;
            hd16   = bus16.m_data;
            hl16   = bus16.m_last;
            if (bus16.fifo_rd_en) cmp("rd_en_while_empty16", 32'(bus16.fifo_empty), 32'd0);
            if (bus16.m_valid && bus16.m_ready) begin
                if (sb16.size() == 0) begin
                    cmp("unexpected_byte16", 32'({bus16.m_last, bus16.m_data}), 32'h1FF);
                end else begin
                    exp_b = sb16.pop_front();
                    cmp("stream16", 32'({bus16.m_last, bus16.m_data}), 32'(exp_b));
                end
            end
        end
    end

    task automatic push4(input logic [7:0] b);
        src4[wr4[7:0]] = b;
        wr4++;
    endtask

    task automatic push16_word(input logic [63:0] w);
        for (int i = 0; i < 8; i++) begin
            src16[wr16[7:0]] = w[8*i +: 8];
            wr16++;
        end
    endtask

    // Expected frame: header, payload, hand-computed checksum with m_last.
    task automatic expect4(input logic [7:0] p0, p1, p2, p3, input logic [7:0] csum);
        sb4.push_back({1'b0, HEADER_DEFAULT});
        sb4.push_back({1'b0, p0});
        sb4.push_back({1'b0, p1});
        sb4.push_back({1'b0, p2});
        sb4.push_back({1'b0, p3});
        sb4.push_back({1'b1, csum});
    endtask

    task automatic drain4();
        int k = 0;
        while (!(sb4.size() == 0 && !busy4 && !bus4.m_valid) && k < 300) begin
            @(posedge sys_clk);
            #1;
            k++;
        end
        cmp("drain4_in_time", 32'(k < 300), 32'd1);
    endtask

    task automatic drain16();
        int k = 0;
        while (!(sb16.size() == 0 && !busy16 && !bus16.m_valid) && k < 300) begin
            @(posedge sys_clk);
            #1;
            k++;
        end
        cmp("drain16_in_time", 32'(k < 300), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [19:0] ready_pat = 20'b1100_1011_0100_0110_1001;
    int unsigned p_base;
    int          run;
    int          k;

    initial begin
        bus4.m_ready  = 1'b1;
        bus16.m_ready = 1'b1;
        repeat (3) @(posedge sys_clk);
        #1;
        cmp("rst_m_valid", 32'(bus4.m_valid), 32'd0);
        cmp("rst_m_data", 32'(bus4.m_data), 32'd0);
        cmp("rst_m_last", 32'(bus4.m_last), 32'd0);
        cmp("rst_busy", 32'(busy4), 32'd0);
        cmp("rst_frame_cnt", 32'(fcnt4), 32'd0);
        cmp("rst_rd_en", 32'(bus4.fifo_rd_en), 32'd0);
        sys_rst    = 1'b1;
        start_en   = 1'b1;
        start_en16 = 1'b1;
        @(posedge sys_clk);
        #1;

        // Basic frame 01..04, checksum 04.
        p_base = pop4;
        expect4(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        push4(8'h01); push4(8'h02); push4(8'h03); push4(8'h04);
        drain4();
        cmp("basic_frame_cnt", 32'(fcnt4), 32'd1);
        cmp("basic_pops", pop4 - p_base, 32'd4);

        // Start gate: three bytes are not enough; the fourth starts the frame next cycle.
        p_base = pop4;
        push4(8'h05); push4(8'h06); push4(8'h07);
        repeat (10) @(posedge sys_clk);
        #1;
        cmp("gate_no_valid", 32'(bus4.m_valid), 32'd0);
        cmp("gate_no_busy", 32'(busy4), 32'd0);
        cmp("gate_no_pops", pop4 - p_base, 32'd0);
        expect4(8'h05, 8'h06, 8'h07, 8'h08, 8'h0C);
        push4(8'h08);
        cmp("gate_pre_header", 32'(bus4.m_valid), 32'd0);
        @(posedge sys_clk);
        #1;
        cmp("gate_hdr_valid", 32'(bus4.m_valid), 32'd1);
        cmp("gate_hdr_data", 32'(bus4.m_data), 32'hA5);
        drain4();
        cmp("gate_frame_cnt", 32'(fcnt4), 32'd2);

        // Back-pressure: ready toggles while the same frame as the first is sent.
        expect4(8'h01, 8'h02, 8'h03, 8'h04, 8'h04);
        push4(8'h01); push4(8'h02); push4(8'h03); push4(8'h04);
        for (int i = 0; i < 20; i++) begin
            bus4.m_ready = ready_pat[i];
            @(posedge sys_clk);
            #1;
        end
        bus4.m_ready = 1'b1;
        drain4();
        cmp("bp_frame_cnt", 32'(fcnt4), 32'd3);

        // Eight queued payloads x1..x4 (checksum always 04) must stream with no bubble.
        start_en = 1'b0;
        p_base   = pop4;
        for (int f = 1; f <= 8; f++) begin
            expect4(8'(16 * f + 1), 8'(16 * f + 2), 8'(16 * f + 3), 8'(16 * f + 4), 8'h04);
            for (int b = 1; b <= 4; b++) push4(8'(16 * f + b));
        end
        @(posedge sys_clk);
        #1;
        start_en = 1'b1;
        k = 0;
        while (!bus4.m_valid && k < 20) begin
            @(negedge sys_clk);
            k++;
        end
        cmp("b2b_started", 32'(k < 20), 32'd1);
        run = 0;
        for (int i = 0; i < 8 * int'(frame_bytes(FL)); i++) begin
            if (bus4.m_valid && busy4) run++;
            @(negedge sys_clk);
        end
        @(posedge sys_clk);
        #1;
        cmp("b2b_no_bubble", 32'(run), 32'd48);
        drain4();
        cmp("b2b_frame_cnt", 32'(fcnt4), 32'd11);
        cmp("b2b_pops", pop4 - p_base, 32'd32);

        // 64-bit words unpacked LSB first into the 16-byte reader; checksum 0x1f.
        sb16.push_back({1'b0, 8'hA5});
        sb16.push_back({1'b0, 8'hEF}); sb16.push_back({1'b0, 8'hCD});
        sb16.push_back({1'b0, 8'hAB}); sb16.push_back({1'b0, 8'h89});
        sb16.push_back({1'b0, 8'h67}); sb16.push_back({1'b0, 8'h45});
        sb16.push_back({1'b0, 8'h23}); sb16.push_back({1'b0, 8'h01});
        sb16.push_back({1'b0, 8'hFF}); sb16.push_back({1'b0, 8'hCE});
        sb16.push_back({1'b0, 8'hAC}); sb16.push_back({1'b0, 8'h8A});
        sb16.push_back({1'b0, 8'h68}); sb16.push_back({1'b0, 8'h46});
        sb16.push_back({1'b0, 8'h24}); sb16.push_back({1'b0, 8'h02});
        sb16.push_back({1'b1, 8'h1F});
        push16_word(64'h0123456789abcdef);
        push16_word(64'h022446688aacceff);
        drain16();
        cmp("w64_frame_cnt", 32'(fcnt16), 32'd1);
        cmp("w64_pops", pop16, 32'd16);

        // Reset in PAY: header and 0x31 are delivered, 0x32 is popped and lost.
        p_base = pop4;
        sb4.push_back({1'b0, 8'hA5});
        sb4.push_back({1'b0, 8'h31});
        push4(8'h31); push4(8'h32); push4(8'h33); push4(8'h34);
        repeat (3) @(posedge sys_clk);
        #1;
        sys_rst = 1'b0;
        #1;
        cmp("abort_m_valid", 32'(bus4.m_valid), 32'd0);
        cmp("abort_busy", 32'(busy4), 32'd0);
        cmp("abort_frame_cnt", 32'(fcnt4), 32'd0);
        cmp("abort_rd_en", 32'(bus4.fifo_rd_en), 32'd0);
        cmp("abort_pops", pop4 - p_base, 32'd2);
        cmp("abort_sb_drained", 32'(sb4.size()), 32'd0);
        repeat (2) @(posedge sys_clk);
        #1;
        sys_rst = 1'b1;
        @(posedge sys_clk);
        #1;
        expect4(8'h33, 8'h34, 8'h35, 8'h36, 8'h04);
        push4(8'h35); push4(8'h36);
        drain4();
        cmp("post_rst_frame_cnt", 32'(fcnt4), 32'd1);
        cmp("end_sb4_empty", 32'(sb4.size()), 32'd0);
        cmp("end_sb16_empty", 32'(sb16.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
